// File: rtl/cpu_test_pkg.sv
// Shared types and helpers for the CPU test sequencer.
package cpu_test_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, CHECK, DONE} state_t;

    // Number of memory lines needed to hold `count` instructions at `ipl` per line.
    function automatic int unsigned lines_of(input int unsigned count, input int unsigned ipl);
        return (count + ipl - 1) / ipl;
    endfunction

endpackage

// File: rtl/cpu_test_line_packer.sv
// Maps (segment, line index) to the target line address and the packed line contents.
module cpu_test_line_packer
    import cpu_test_pkg::*;
#(
    parameter int NUM_CODES   = 1,
    parameter int TOTAL_INSTR = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int LADDR_WIDTH = 28,
    parameter int SEG_W       = 1,
    parameter int LINE_W      = 2,
    parameter logic [NUM_CODES-1:0][LADDR_WIDTH-1:0]   CODE_ADDRS       = '0,
    parameter logic [NUM_CODES-1:0][31:0]              CODE_START_INSTR = '0,
    parameter logic [TOTAL_INSTR-1:0][INSTR_WIDTH-1:0] CODE_INSTR_DATAS = '0
) (
    input  logic [SEG_W-1:0]       seg,
    input  logic [LINE_W-1:0]      line,
    output logic [LADDR_WIDTH-1:0] laddr,
    output logic [LINE_WIDTH-1:0]  wdata
);

    localparam int IPL = LINE_WIDTH / INSTR_WIDTH;

    int unsigned first, last, k;
    logic [LADDR_WIDTH-1:0] base;

    always_comb begin
        first = 0;
        last  = TOTAL_INSTR;
        k     = 0;
        base  = '0;
        wdata = '0;
        // The segment ends where the next one starts; the last one ends at TOTAL_INSTR.
        for (int s = 0; s < NUM_CODES; s++) begin
            if (int'(seg) == s) begin
                first = CODE_START_INSTR[s];
                base  = CODE_ADDRS[s];
            end
            if (int'(seg) == s - 1) last = CODE_START_INSTR[s];
        end
        laddr = base + LADDR_WIDTH'(line);
        for (int j = 0; j < IPL; j++) begin
            k = first + int'(line) * IPL + j;
            if (k < last) wdata[j*INSTR_WIDTH +: INSTR_WIDTH] = CODE_INSTR_DATAS[k];
        end
    end

endmodule

// File: rtl/cpu_test_sequencer.sv
// Self-checking CPU harness: load code lines, run the CPU with a timeout, drain, read back and compare.
module cpu_test_sequencer
    import cpu_test_pkg::*;
#(
    parameter int NUM_CODES   = 1,
    parameter int TOTAL_INSTR = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int LADDR_WIDTH = 28,
    parameter logic [NUM_CODES-1:0][LADDR_WIDTH-1:0]   CODE_ADDRS       = 'h100,
    parameter logic [NUM_CODES-1:0][31:0]              CODE_START_INSTR = '0,
    parameter logic [TOTAL_INSTR-1:0][INSTR_WIDTH-1:0] CODE_INSTR_DATAS = '0,
    parameter int NUM_CHECKS  = 1,
    parameter logic [NUM_CHECKS-1:0][LADDR_WIDTH-1:0]  CHECK_ADDRS = '0,
    parameter logic [NUM_CHECKS-1:0][LINE_WIDTH-1:0]   CHECK_DATAS = '0,
    parameter logic [NUM_CHECKS-1:0][LINE_WIDTH-1:0]   CHECK_MASKS = '1,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DRAIN_CYCLES   = 45,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    output logic                              cpu_reset,
    input  logic                              offload,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic                              mem_req_write,
    output logic [LADDR_WIDTH-1:0]            mem_req_laddr,
    output logic [LINE_WIDTH-1:0]             mem_req_wdata,
    input  logic                              mem_rsp_valid,
    input  logic [LINE_WIDTH-1:0]             mem_rsp_rdata,
    output logic                              done,
    output logic                              pass,
    output logic                              timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0]   fail_index,
    output logic [CNT_WIDTH-1:0]              run_cycles
);

    localparam int IPL       = LINE_WIDTH / INSTR_WIDTH;
    localparam int MAX_LINES = int'(lines_of(TOTAL_INSTR, IPL));
    localparam int SEG_W     = (NUM_CODES > 1) ? $clog2(NUM_CODES) : 1;
    localparam int LINE_W    = (MAX_LINES > 0) ? $clog2(MAX_LINES + 1) : 1;
    localparam int FIW       = $clog2(NUM_CHECKS + 1);

    state_t state, state_n;
    logic                   req_valid, req_write, rd_pending, timeout_q;
    logic [LADDR_WIDTH-1:0] req_laddr;
    logic [LINE_WIDTH-1:0]  req_wdata;
    logic [SEG_W-1:0]       seg_idx, first_seg, nxt_seg, pk_seg;
    logic [LINE_W-1:0]      line_idx, nxt_line, pk_line;
    logic                   first_ok, nxt_ok, accept, rsp_hit, last_chk;
    logic [CNT_WIDTH-1:0]   run_cnt;
    logic [31:0]            drain_cnt;
    logic [FIW-1:0]         chk_idx, fail_idx;
    logic [LADDR_WIDTH-1:0] pk_laddr;
    logic [LINE_WIDTH-1:0]  pk_wdata;

    function automatic int seg_lines(input int s);
        int hi;
        hi = TOTAL_INSTR;
        for (int t = 0; t < NUM_CODES; t++) if (t == s + 1) hi = int'(CODE_START_INSTR[t]);
        return int'(lines_of(hi - int'(CODE_START_INSTR[s]), IPL));
    endfunction

    // Walk to the next real line, skipping segments that hold no instructions.
    always_comb begin
        first_ok  = 1'b0;
        first_seg = '0;
        for (int s = NUM_CODES - 1; s >= 0; s--)
            if (seg_lines(s) != 0) begin
                first_ok  = 1'b1;
                first_seg = SEG_W'(s);
            end
        nxt_ok   = 1'b0;
        nxt_seg  = seg_idx;
        nxt_line = line_idx + 1'b1;
        if (int'(line_idx) + 1 < seg_lines(int'(seg_idx))) nxt_ok = 1'b1;
        else begin
            nxt_line = '0;
            for (int s = NUM_CODES - 1; s >= 0; s--)
                if (s > int'(seg_idx) && seg_lines(s) != 0) begin
                    nxt_ok  = 1'b1;
                    nxt_seg = SEG_W'(s);
                end
        end
    end

    assign pk_seg  = (state == LOAD) ? nxt_seg : first_seg;
    assign pk_line = (state == LOAD) ? nxt_line : '0;

    cpu_test_line_packer #(
        .NUM_CODES(NUM_CODES), .TOTAL_INSTR(TOTAL_INSTR), .INSTR_WIDTH(INSTR_WIDTH),
        .LINE_WIDTH(LINE_WIDTH), .LADDR_WIDTH(LADDR_WIDTH), .SEG_W(SEG_W), .LINE_W(LINE_W),
        .CODE_ADDRS(CODE_ADDRS), .CODE_START_INSTR(CODE_START_INSTR),
        .CODE_INSTR_DATAS(CODE_INSTR_DATAS)
    ) u_packer (
        .seg(pk_seg), .line(pk_line), .laddr(pk_laddr), .wdata(pk_wdata)
    );

    assign accept   = req_valid && mem_req_ready;
    assign rsp_hit  = mem_rsp_valid && rd_pending;
    assign last_chk = (chk_idx == FIW'(NUM_CHECKS - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, DONE: if (start) state_n = LOAD;
            LOAD:       if (!req_valid || (accept && !nxt_ok)) state_n = RUN;
            RUN: begin
                if (offload)                                     state_n = DRAIN;
                else if (run_cnt >= CNT_WIDTH'(TIMEOUT_CYCLES))  state_n = DONE;
            end
            DRAIN:      if (drain_cnt + 32'd1 >= 32'(DRAIN_CYCLES)) state_n = CHECK;
            CHECK:      if (rsp_hit && last_chk) state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_valid  <= 1'b0;
            req_write  <= 1'b0;
            req_laddr  <= '0;
            req_wdata  <= '0;
            seg_idx    <= '0;
            line_idx   <= '0;
            run_cnt    <= '0;
            drain_cnt  <= '0;
            chk_idx    <= '0;
            rd_pending <= 1'b0;
            fail_idx   <= FIW'(NUM_CHECKS);
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    timeout_q <= 1'b0;
                    fail_idx  <= FIW'(NUM_CHECKS);
                    run_cnt   <= '0;
                    req_valid <= first_ok;
                    req_write <= 1'b1;
                    req_laddr <= pk_laddr;
                    req_wdata <= pk_wdata;
                    seg_idx   <= first_seg;
                    line_idx  <= '0;
                end
                LOAD: if (accept) begin
                    req_valid <= nxt_ok;
                    req_laddr <= pk_laddr;
                    req_wdata <= pk_wdata;
                    seg_idx   <= nxt_seg;
                    line_idx  <= nxt_line;
                end
                RUN: begin
                    if (offload)                                    drain_cnt <= '0;
                    else if (run_cnt >= CNT_WIDTH'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
                    else if (run_cnt != '1)                         run_cnt   <= run_cnt + 1'b1;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 32'd1;
                    if (state_n == CHECK) begin
                        req_valid <= 1'b1;
                        req_write <= 1'b0;
                        req_laddr <= CHECK_ADDRS[0];
                        req_wdata <= '0;
                        chk_idx   <= '0;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        req_valid  <= 1'b0;
                        rd_pending <= 1'b1;
                    end
                    if (rsp_hit) begin
                        rd_pending <= 1'b0;
                        if ((((mem_rsp_rdata ^ CHECK_DATAS[chk_idx]) & CHECK_MASKS[chk_idx]) != '0)
                            && fail_idx == FIW'(NUM_CHECKS))
                            fail_idx <= chk_idx;
                        if (!last_chk) begin
                            chk_idx   <= chk_idx + 1'b1;
                            req_valid <= 1'b1;
                            req_laddr <= CHECK_ADDRS[chk_idx + 1'b1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_reset     = !(state == RUN || state == DRAIN);
    assign mem_req_valid = req_valid;
    assign mem_req_write = req_write;
    assign mem_req_laddr = req_laddr;
    assign mem_req_wdata = req_wdata;
    assign done          = (state == DONE);
    assign pass          = done && (fail_idx == FIW'(NUM_CHECKS)) && !timeout_q;
    assign timeout       = timeout_q;
    assign fail_index    = fail_idx;
    assign run_cycles    = run_cnt;

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Bench for cpu_test_sequencer: behavioural memory/CPU model plus directed scenarios.
module tb_cpu_test_sequencer;

    localparam int NC = 2, TI = 9, IW = 32, LW = 128, AW = 28, IPL = LW / IW;
    localparam int NCHK = 3, TO = 100, DR = 45, CW = 32;
    localparam logic [NC-1:0][AW-1:0] C_ADDRS = {28'h200, 28'h100};
    localparam logic [NC-1:0][31:0]   C_START = {32'd5, 32'd0};
    localparam logic [TI-1:0][IW-1:0] C_INSTR = {32'hA000_0008, 32'hA000_0007, 32'hA000_0006,
        32'hA000_0005, 32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    localparam logic [NCHK-1:0][AW-1:0] K_ADDRS = {28'h302, 28'h301, 28'h300};
    localparam logic [NCHK-1:0][LW-1:0] K_DATAS = {128'h3333_4444_5555_6666_7777_8888_9999_AAAA,
        128'h2222_0000_1111_0000_2222_0000_1111_0001, 128'h1111_2222_3333_4444_5555_6666_7777_8888};
    localparam logic [NCHK-1:0][LW-1:0] K_MASKS = {128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};

    logic clock = 0, reset = 1, start = 0, offload = 0;
    logic mem_req_ready = 1, mem_rsp_valid = 0;
    logic [LW-1:0] mem_rsp_rdata = '0;
    logic cpu_reset, mem_req_valid, mem_req_write, done, pass, timeout;
    logic [AW-1:0] mem_req_laddr;
    logic [LW-1:0] mem_req_wdata;
    logic [1:0] fail_index;
    logic [CW-1:0] run_cycles;

    cpu_test_sequencer #(
        .NUM_CODES(NC), .TOTAL_INSTR(TI), .INSTR_WIDTH(IW), .LINE_WIDTH(LW), .LADDR_WIDTH(AW),
        .CODE_ADDRS(C_ADDRS), .CODE_START_INSTR(C_START), .CODE_INSTR_DATAS(C_INSTR),
        .NUM_CHECKS(NCHK), .CHECK_ADDRS(K_ADDRS), .CHECK_DATAS(K_DATAS), .CHECK_MASKS(K_MASKS),
        .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(DR), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cpu_reset(cpu_reset), .offload(offload),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
        .mem_req_laddr(mem_req_laddr), .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata), .done(done), .pass(pass), .timeout(timeout),
        .fail_index(fail_index), .run_cycles(run_cycles)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    int low_cnt = 0, n_wr = 0, n_rd = 0, off_at = -1, rsp_cnt = 0;
    bit ready_rand = 0, hold = 0, h_write;
    logic [AW-1:0] h_addr, rsp_addr;
    logic [LW-1:0] h_data;
    logic [LW-1:0] mem [logic [AW-1:0]];
    logic [AW-1:0] exp_addr [$];
    logic [LW-1:0] exp_data [$];

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, req);
        end
    endtask

    // First check whose masked compare differs, NUM_CHECKS if all agree.
    function automatic int model_fail();
        for (int i = 0; i < NCHK; i++)
            if (((mem[K_ADDRS[i]] ^ K_DATAS[i]) & K_MASKS[i]) != '0) return i;
        return NCHK;
    endfunction

    // Expected write stream: instruction k of a segment lands in line base+k/IPL, lane k%IPL.
    initial begin
        int seg_lo [NC+1];
        logic [LW-1:0] line;
        for (int s = 0; s < NC; s++) seg_lo[s] = int'(C_START[s]);
        seg_lo[NC] = TI;
        line = '0;
        for (int s = 0; s < NC; s++)
            for (int k = 0; k < seg_lo[s+1] - seg_lo[s]; k++) begin
                if (k % IPL == 0) line = '0;
                line[(k % IPL)*IW +: IW] = C_INSTR[seg_lo[s] + k];
                if (k % IPL == IPL - 1 || k == seg_lo[s+1] - seg_lo[s] - 1) begin
                    exp_addr.push_back(C_ADDRS[s] + AW'(k / IPL));
                    exp_data.push_back(line);
                end
            end
    end

    // Memory, CPU and per-cycle protocol model; all activity on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                hold = 0; rsp_cnt = 0; mem_rsp_valid = 0; offload = 0;
            end else begin
                offload = 0;
                if (!cpu_reset) begin
                    if (low_cnt == off_at) offload = 1;
                    low_cnt++;
                    check("quiet_while_cpu_runs", mem_req_valid, 0);
                end
                mem_rsp_valid = 0;
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        mem_rsp_valid = 1;
                        mem_rsp_rdata = mem[rsp_addr];
                    end
                end
                if (hold) begin
                    check("hold_valid", mem_req_valid, 1);
                    check("hold_write", mem_req_write, h_write);
                    check("hold_addr", mem_req_laddr, h_addr);
                    check("hold_data", mem_req_wdata, h_data);
                end
                hold = 0;
                mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mem_req_valid) begin
                    if (!mem_req_ready) begin
                        hold = 1; h_write = mem_req_write; h_addr = mem_req_laddr; h_data = mem_req_wdata;
                    end else if (mem_req_write) begin
                        check("write_in_range", n_wr < exp_addr.size(), 1);
                        if (n_wr < exp_addr.size()) begin
                            check("write_addr", mem_req_laddr, exp_addr[n_wr]);
                            check("write_data", mem_req_wdata, exp_data[n_wr]);
                        end
                        mem[mem_req_laddr] = mem_req_wdata;
                        n_wr++;
                    end else begin
                        check("read_in_range", n_rd < NCHK, 1);
                        if (n_rd < NCHK) check("read_addr", mem_req_laddr, K_ADDRS[n_rd]);
                        n_rd++;
                        rsp_cnt = 2;
                        rsp_addr = mem_req_laddr;
                    end
                end
            end
        end
    end

    task automatic run_test(input bit rnd, input int off, input bit bad);
        bit exp_to;
        int exp_fi;
        ready_rand = rnd;
        off_at = off;
        mem.delete();
        for (int i = 0; i < NCHK; i++) mem[K_ADDRS[i]] = K_DATAS[i];
        if (bad) begin
            mem[K_ADDRS[1]] = K_DATAS[1] ^ 128'h1;
            mem[K_ADDRS[2]] = K_DATAS[2] ^ (128'h1 << 100);
        end
        low_cnt = 0; n_wr = 0; n_rd = 0;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        check("start_clears_timeout", timeout, 0);
        check("start_clears_fail_index", fail_index, NCHK);
        for (int i = 0; i < 200 && cpu_reset; i++) @(negedge clock);
        check("cpu_released", cpu_reset, 0);
        repeat (10) @(negedge clock);
        start = 1;
        @(negedge clock); start = 0;
        for (int i = 0; i < 1000 && !done; i++) @(negedge clock);
        check("done_reached", done, 1);
        exp_to = (off < 0);
        exp_fi = exp_to ? NCHK : model_fail();
        check("timeout", timeout, exp_to);
        check("fail_index", fail_index, exp_fi);
        check("pass", pass, !exp_to && exp_fi == NCHK);
        check("run_cycles", run_cycles, exp_to ? TO : off);
        check("write_count", n_wr, exp_addr.size());
        check("read_count", n_rd, exp_to ? 0 : NCHK);
        check("cpu_low_cycles", low_cnt, exp_to ? TO + 1 : off + 1 + DR);
        check("cpu_reset_done", cpu_reset, 1);
        repeat (3) @(negedge clock);
        check("done_holds", done, 1);
    endtask

    task automatic pin_lines();
        check("line_100", mem[28'h100], 128'hA0000003_A0000002_A0000001_A0000000);
        check("line_101", mem[28'h101], 128'h00000000_00000000_00000000_A0000004);
        check("line_200", mem[28'h200], 128'hA0000008_A0000007_A0000006_A0000005);
        check("writes_3", n_wr, 3);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_valid", mem_req_valid, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_fail_index", fail_index, NCHK);
        check("rst_run_cycles", run_cycles, 0);
        reset = 0;

        run_test(0, 37, 0);                 // clean run, ready always high
        pin_lines();
        check("t1_pass", pass, 1);
        check("t1_run_cycles", run_cycles, 37);

        run_test(1, 20, 0);                 // back-pressure
        pin_lines();

        run_test(0, -1, 0);                 // no offload
        check("t4_timeout", timeout, 1);
        check("t4_run_cycles", run_cycles, TO);

        run_test(1, 30, 1);                 // masked-off vs compared difference
        check("t5_fail_index", fail_index, 2);
        check("t5_pass", pass, 0);

        ready_rand = 1;                     // reset in the middle of loading
        low_cnt = 0; n_wr = 0; n_rd = 0;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        for (int i = 0; i < 100 && !(n_wr >= 1 && n_wr < 3 && mem_req_valid); i++) @(negedge clock);
        check("t6_mid_load", mem_req_valid, 1);
        #2 reset = 1;
        #1;
        check("t6_valid_drops", mem_req_valid, 0);
        check("t6_cpu_reset", cpu_reset, 1);
        @(negedge clock); reset = 0;
        run_test(1, 12, 0);
        pin_lines();
        check("t6_pass", pass, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required end within 500000 time units");
        $fatal(1);
    end

endmodule
